// File: rtl/branch_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_alu_sequencer
//  Description : Multi-cycle branch-resolution controller. Accepts one branch
//                request over a valid/ready handshake, borrows the shared
//                32-bit ALU for a SUB (compare) phase and an ADD (target)
//                phase, then returns taken/target over a second valid/ready
//                handshake.
//  Ports       :
//      clk, rst                 - clock, asynchronous active-high reset
//      req_valid/req_ready      - request handshake
//      req_funct3               - RV32I B-type funct3
//      req_rs1, req_rs2         - compare operands
//      req_pc, req_imm          - branch PC and sign-extended offset
//      alu_operand_a/b, alu_op  - drive the shared ALU
//      alu_result, alu_zero_flag- ALU response (combinational, same cycle)
//      resp_valid/resp_ready    - response handshake
//      resp_taken, resp_target  - resolution
//      resp_error               - illegal funct3 (010 / 011)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_alu_sequencer #(
    parameter logic [3:0] ALU_ADD_OP = 4'b0000,
    parameter logic [3:0] ALU_SUB_OP = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_imm,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero_flag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_taken,
    output logic [31:0] resp_target,
    output logic        resp_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_TGT  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rs1_q,    rs1_d;
    logic [31:0] rs2_q,    rs2_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] imm_q,    imm_d;
    logic        taken_q,  taken_d;
    logic [31:0] target_q, target_d;
    logic        error_q,  error_d;

    logic w_eq;
    logic w_slt;
    logic w_ult;
    logic w_sign_diff;

    // When the operand signs differ the subtraction can overflow, so the
    // ordering is decided by the sign bits alone; otherwise the sign of the
    // difference is exact for both signed and unsigned compares.
    assign w_sign_diff = rs1_q[31] ^ rs2_q[31];
    assign w_eq        = alu_zero_flag;
    assign w_slt       = w_sign_diff ? rs1_q[31] : alu_result[31];
    assign w_ult       = w_sign_diff ? rs2_q[31] : alu_result[31];

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        taken_d       = taken_q;
        target_d      = target_q;
        error_d       = error_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        alu_operand_a = 32'd0;
        alu_operand_b = 32'd0;
        alu_op        = ALU_ADD_OP;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = req_funct3;
                    rs1_d    = req_rs1;
                    rs2_d    = req_rs2;
                    pc_d     = req_pc;
                    imm_d    = req_imm;
                    // funct3 010/011 are unassigned B-type encodings
                    if (req_funct3[2:1] == 2'b01) begin
                        error_d  = 1'b1;
                        taken_d  = 1'b0;
                        target_d = 32'd0;
                        state_d  = ST_RESP;
                    end else begin
                        error_d  = 1'b0;
                        state_d  = ST_CMP;
                    end
                end
            end

            ST_CMP: begin
                alu_operand_a = rs1_q;
                alu_operand_b = rs2_q;
                alu_op        = ALU_SUB_OP;
                case (funct3_q)
                    3'b000:  taken_d = w_eq;
                    3'b001:  taken_d = ~w_eq;
                    3'b100:  taken_d = w_slt;
                    3'b101:  taken_d = ~w_slt;
                    3'b110:  taken_d = w_ult;
                    3'b111:  taken_d = ~w_ult;
                    default: taken_d = 1'b0;
                endcase
                state_d = ST_TGT;
            end

            ST_TGT: begin
                alu_operand_a = pc_q;
                alu_operand_b = taken_q ? imm_q : 32'd4;
                alu_op        = ALU_ADD_OP;
                target_d      = alu_result;
                state_d       = ST_RESP;
            end

            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign resp_taken  = taken_q;
    assign resp_target = target_q;
    assign resp_error  = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            pc_q     <= 32'd0;
            imm_q    <= 32'd0;
            taken_q  <= 1'b0;
            target_q <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            error_q  <= error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_alu_sequencer
//  Description : Self-checking bench for branch_alu_sequencer. Provides a
//                behavioural ALU, applies directed and random branches, and
//                compares against a reference model of RV32I branch rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_alu_sequencer;

    localparam logic [3:0] C_ADD = 4'b0000;
    localparam logic [3:0] C_SUB = 4'b0001;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2, req_pc, req_imm;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero_flag;
    logic        resp_valid, resp_ready, resp_taken, resp_error;
    logic [31:0] resp_target;

    int n_vec;
    int n_err;

    branch_alu_sequencer #(
        .ALU_ADD_OP(C_ADD),
        .ALU_SUB_OP(C_SUB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_pc       (req_pc),
        .req_imm      (req_imm),
        .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero_flag(alu_zero_flag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_taken   (resp_taken),
        .resp_target  (resp_target),
        .resp_error   (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        alu_result = 32'd0;
        if (alu_op == C_SUB) alu_result = alu_operand_a - alu_operand_b;
        else                 alu_result = alu_operand_a + alu_operand_b;
        alu_zero_flag = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I branch semantics from plain signed/unsigned compares
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  output logic t, output logic [31:0] tgt, output logic err);
        err = 1'b0;
        t   = 1'b0;
        case (f3)
            3'b000: t = (a == b);
            3'b001: t = (a != b);
            3'b100: t = ($signed(a) <  $signed(b));
            3'b101: t = ($signed(a) >= $signed(b));
            3'b110: t = (a <  b);
            3'b111: t = (a >= b);
            default: err = 1'b1;
        endcase
        if (err)    tgt = 32'd0;
        else if (t) tgt = pc + imm;
        else        tgt = pc + 32'd4;
    endfunction

    task automatic chk_alu_idle(input string tag);
        chk({tag, "_alu_a"},  alu_operand_a, 32'd0);
        chk({tag, "_alu_b"},  alu_operand_b, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, {28'd0, C_ADD});
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] imm, input int bp);
        logic        et;
        logic [31:0] etg;
        logic        ee;
        int          lat;
        int          exp_lat;
        model(f3, a, b, pc, imm, et, etg, ee);
        exp_lat = ee ? 1 : 3;

        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_pc     = pc;
        req_imm    = imm;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk_alu_idle("idle");
        @(posedge clk);
        #1;
        // Drop the request and scramble the bus; captured values must hold
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_rs1    = $urandom;
        req_rs2    = $urandom;
        req_pc     = $urandom;
        req_imm    = $urandom;

        lat = 1;
        while (!resp_valid && lat < 8) begin
            if (!ee && lat == 1) begin
                chk("cmp_alu_a",  alu_operand_a, a);
                chk("cmp_alu_b",  alu_operand_b, b);
                chk("cmp_alu_op", {28'd0, alu_op}, {28'd0, C_SUB});
            end
            if (!ee && lat == 2) begin
                chk("tgt_alu_a",  alu_operand_a, pc);
                chk("tgt_alu_b",  alu_operand_b, et ? imm : 32'd4);
                chk("tgt_alu_op", {28'd0, alu_op}, {28'd0, C_ADD});
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_taken", {31'd0, resp_taken}, {31'd0, et});
        chk("resp_target", resp_target, etg);
        chk("resp_error", {31'd0, resp_error}, {31'd0, ee});
        chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
        chk_alu_idle("resp");

        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid",  {31'd0, resp_valid}, 32'd1);
            chk("bp_taken",  {31'd0, resp_taken}, {31'd0, et});
            chk("bp_target", resp_target, etg);
            chk("bp_error",  {31'd0, resp_error}, {31'd0, ee});
            chk("bp_ready",  {31'd0, req_ready}, 32'd0);
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("post_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic [2:0]  f3;
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_rs1    = 32'd0;
        req_rs2    = 32'd0;
        req_pc     = 32'd0;
        req_imm    = 32'd0;
        resp_ready = 1'b0;

        #12;
        chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_taken", {31'd0, resp_taken}, 32'd0);
        chk("rst_resp_target", resp_target, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk_alu_idle("rst");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_branch(3'b000, 32'd100, 32'd100, 32'h1000, 32'h20, 0);
        run_branch(3'b001, 32'd100, 32'd100, 32'h1000, 32'h20, 0);
        run_branch(3'b100, 32'hFFFFFFF0, 32'h2, 32'h200, 32'hFFFFFFF8, 0);
        run_branch(3'b110, 32'hFFFFFFF0, 32'h2, 32'h200, 32'hFFFFFFF8, 0);
        run_branch(3'b101, 32'hFFFFFFF0, 32'hFFFFFFFE, 32'h200, 32'hFFFFFFF8, 0);
        run_branch(3'b000, 32'd7, 32'd7, 32'h3000, 32'h40, 5);
        run_branch(3'b010, 32'd1, 32'd2, 32'h400, 32'h10, 0);
        run_branch(3'b011, 32'd5, 32'd5, 32'h400, 32'h10, 2);
        run_branch(3'b111, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFC, 32'h8, 0);

        // Reset asserted asynchronously while the sequencer is in TGT
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_rs1    = 32'd9;
        req_rs2    = 32'd9;
        req_pc     = 32'h5000;
        req_imm    = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_tgt_alu_a", alu_operand_a, 32'h5000);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready",  {31'd0, req_ready}, 32'd1);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk_alu_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        run_branch(3'b001, 32'd1, 32'd2, 32'h6000, 32'hFFFFFF00, 1);

        // Randomized branches
        for (int k = 0; k < 150; k++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h80000000;
                2:       b = a + 32'($urandom_range(0, 3)) - 32'd1;
                default: b = $urandom;
            endcase
            r = $urandom;
            run_branch(f3, a, b, {$urandom} & 32'hFFFFFFFC,
                       {{19{r[12]}}, r[12:1], 1'b0}, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
